uproc_ctrl: RTL

Fetch/decode/execute sequencer for the 8-bit uProcessor. It owns the program counter, the accumulator, the carry flag and an 8x8 register file. It fetches instructions over a req/ack program-memory port and drives the external combinational 8-bit ALU (3-bit op code, A/R operands, carry in/out). It sits between program memory and the ALU and is the only master of both.

---
 rtl/uproc_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uproc_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit uProcessor: owns pc, acc, carry and
// an 8x8 register file, fetches over a req/ack port and drives the external ALU.
module uproc_ctrl #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter bit         START_RUN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [2:0] alu_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_r,
  output logic       alu_ci,
  input  logic       alu_co,
  input  logic [7:0] alu_out,
  output logic [7:0] acc,
  output logic       carry,
  output logic [7:0] pc,
  output logic       halted,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic        carry_q, carry_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  opr_q, opr_d;
  logic [7:0]  regs_q [8];
  logic        regWe;
  logic [3:0]  op;
  logic [2:0]  n;

  assign op = ir_q[7:4];
  assign n  = ir_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else if (regWe) begin
      regs_q[n] <= acc_q;
    end
  end

  // Request is a pure function of state so an async reset drops it at once.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
    regWe    = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || START_RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          4'h9, 4'hA: state_d = S_FETCH2;
          4'hF:       state_d = S_HALT;
          default:    state_d = S_EXEC;
        endcase
      end
      S_FETCH2: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          opr_d   = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            acc_d   = alu_out;
            carry_d = alu_co;
          end
          4'h6: begin
            acc_d   = regs_q[n];
            carry_d = 1'b0;
          end
          4'h7: regWe = 1'b1;
          4'h8: acc_d = {4'h0, ir_q[3:0]};
          4'h9: pc_d = opr_q;
          4'hA: if (carry_q) pc_d = opr_q;
          4'hB: carry_d = 1'b0;
          4'hC: carry_d = 1'b1;
          default: ;
        endcase
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign alu_code  = ir_q[6:4];
  assign alu_a     = acc_q;
  assign alu_r     = regs_q[n];
  assign alu_ci    = ir_q[3] & carry_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_data  = regs_q[dbg_sel];

endmodule
